// File: rtl/encoder_pkg.sv
// -----------------------------------------------------------------------------
// encoder_pkg : shared types and default sizes for the encoder datapath blocks
// Revision    : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

package encoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } rd_pack_state_e;

  localparam int RD_DATA_WIDTH_DEFAULT = 64;
  localparam int RD_PACK_DEFAULT       = 4;
  localparam int RD_LEN_WIDTH_DEFAULT  = 16;

endpackage

`default_nettype wire

// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer : drains FIFO words frame-by-frame and packs PACK words per beat
// Revision       : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module fifo_rd_packer
  import encoder_pkg::*;
#(
  parameter int DATA_WIDTH = RD_DATA_WIDTH_DEFAULT,
  parameter int PACK       = RD_PACK_DEFAULT,
  parameter int LEN_WIDTH  = RD_LEN_WIDTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      fifo_data_i,
  input  logic                       fifo_valid_i,
  output logic                       fifo_pop_o,
  input  logic                       start_i,
  input  logic [LEN_WIDTH-1:0]       len_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [PACK*DATA_WIDTH-1:0] out_data_o,
  output logic [PACK-1:0]            out_keep_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic                       out_last_o
);

  localparam int LANE_W = $clog2(PACK);

  rd_pack_state_e            r_state;
  rd_pack_state_e            w_state_nxt;
  logic [LANE_W-1:0]         r_lane;
  logic [LEN_WIDTH-1:0]      r_remaining;
  logic [PACK*DATA_WIDTH-1:0] r_data;
  logic [PACK-1:0]           r_keep;
  logic                      r_last;

  logic w_pop_fire;
  logic w_beat_full;
  logic w_frame_end;
  logic w_send_fire;
  logic w_start_frame;
  logic w_clear_beat;

  assign w_pop_fire    = (r_state == FILL) && fifo_valid_i;
  assign w_beat_full   = (r_lane == LANE_W'(PACK - 1));
  assign w_frame_end   = (r_remaining == LEN_WIDTH'(1));
  assign w_send_fire   = (r_state == SEND) && out_ready_i;
  assign w_start_frame = (r_state == IDLE) && start_i && (len_i != '0);
  // A fresh beat starts either at frame start or after a non-final handshake.
  assign w_clear_beat  = w_start_frame || (w_send_fire && !r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    fifo_pop_o  = 1'b0;
    out_valid_o = 1'b0;
    done_o      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_nxt = (len_i != '0) ? FILL : DONE;
        end
      end
      FILL: begin
        fifo_pop_o = fifo_valid_i;
        if (w_pop_fire && (w_beat_full || w_frame_end)) begin
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          w_state_nxt = r_last ? DONE : FILL;
        end
      end
      DONE: begin
        done_o      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane      <= '0;
      r_remaining <= '0;
      r_data      <= '0;
      r_keep      <= '0;
      r_last      <= 1'b0;
    end else if (w_clear_beat) begin
      r_lane <= '0;
      r_data <= '0;
      r_keep <= '0;
      r_last <= 1'b0;
      if (w_start_frame) begin
        r_remaining <= len_i;
      end
    end else if (w_pop_fire) begin
      for (int k = 0; k < PACK; k++) begin
        if (r_lane == LANE_W'(k)) begin
          r_data[k*DATA_WIDTH +: DATA_WIDTH] <= fifo_data_i;
          r_keep[k]                          <= 1'b1;
        end
      end
      r_remaining <= r_remaining - LEN_WIDTH'(1);
      r_lane      <= w_beat_full ? '0 : r_lane + LANE_W'(1);
      r_last      <= w_frame_end;
    end
  end

  assign busy_o     = (r_state != IDLE);
  assign out_last_o = (r_state == SEND) && r_last;
  assign out_data_o = r_data;
  assign out_keep_o = r_keep;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_packer : upstream sync FIFO model plus beat scoreboard for the packer
// Revision          : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_fifo_rd_packer;
  import encoder_pkg::*;

  localparam int DW = 64;
  localparam int PK = 4;
  localparam int LW = 16;
  localparam int BW = DW * PK;

  typedef struct {
    logic [BW-1:0] data;
    logic [PK-1:0] keep;
    logic          last;
  } beat_t;
  typedef logic [DW-1:0] word_q_t[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] fifo_data;
  logic          fifo_valid;
  logic          fifo_pop;
  logic          start = 1'b0;
  logic [LW-1:0] len_in = '0;
  logic          busy;
  logic          done;
  logic [BW-1:0] out_data;
  logic [PK-1:0] out_keep;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;

  logic          push = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic [DW-1:0] fifo_mem [0:63];
  logic [6:0]    r_wptr;
  logic [6:0]    r_rptr;

  beat_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int busy_cnt, done_cnt, valid_cnt, fire_cnt;

  always #5 clk = ~clk;

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK), .LEN_WIDTH(LW)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_data_i  (fifo_data),
    .fifo_valid_i (fifo_valid),
    .fifo_pop_o   (fifo_pop),
    .start_i      (start),
    .len_i        (len_in),
    .busy_o       (busy),
    .done_o       (done),
    .out_data_o   (out_data),
    .out_keep_o   (out_keep),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_last_o   (out_last)
  );

  // First-word-fall-through FIFO sharing the packer's reset.
  assign fifo_valid = (r_wptr != r_rptr);
  assign fifo_data  = fifo_mem[r_rptr[5:0]];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (push) begin
        fifo_mem[r_wptr[5:0]] <= push_data;
        r_wptr <= r_wptr + 7'd1;
      end
      if (fifo_pop && fifo_valid) r_rptr <= r_rptr + 7'd1;
    end
  end

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    beat_t dmy;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (out_valid) valid_cnt++;
        if (fifo_pop && fifo_valid) fire_cnt++;
        check("pop_gated", fifo_pop && !fifo_valid, 0);
        if (out_valid) begin
          check("pop_in_send", fifo_pop, 0);
          if (sb.size() == 0) begin
            check("unexpected_beat", out_valid, 0);
          end else begin
            check("beat_data", out_data, sb[0].data);
            check("beat_keep", out_keep, sb[0].keep);
            check("beat_last", out_last, sb[0].last);
            if (out_ready) dmy = sb.pop_front();
          end
        end else begin
          check("last_unqualified", out_last, 0);
        end
      end
    end
  end

  task automatic expect_frame(input word_q_t w, input int len);
    for (int b = 0; b < len; b += PK) begin
      beat_t t;
      t.data = '0;
      t.keep = '0;
      for (int k = 0; k < PK; k++) begin
        if (b + k < len) begin
          t.data[k*DW +: DW] = w[b+k];
          t.keep[k] = 1'b1;
        end
      end
      t.last = (b + PK >= len);
      sb.push_back(t);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    push = 1'b1;
    push_data = w;
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic start_frame(input int len);
    start = 1'b1;
    len_in = LW'(len);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_cnt();
    busy_cnt = 0; done_cnt = 0; valid_cnt = 0; fire_cnt = 0;
  endtask

  task automatic finish_frame(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, done_cnt != 0, 1);
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pop"}, fifo_pop, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_keep"}, out_keep, 0);
  endtask

  initial begin
    word_q_t wq;
    int n;
    clear_cnt();
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1) two full beats
    wq.delete();
    for (int i = 1; i <= 8; i++) begin wq.push_back(DW'(i)); push_word(DW'(i)); end
    expect_frame(wq, 8);
    clear_cnt();
    start_frame(8);
    finish_frame("t1", 60);
    check("t1_valid_cycles", valid_cnt, 2);
    check("t1_pops", fire_cnt, 8);

    // 2) partial final beat
    wq.delete();
    for (int i = 0; i < 6; i++) begin wq.push_back(DW'(8'hA0 + i)); push_word(DW'(8'hA0 + i)); end
    expect_frame(wq, 6);
    clear_cnt();
    start_frame(6);
    finish_frame("t2", 60);
    check("t2_pops", fire_cnt, 6);

    // 3) trickling FIFO
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(DW'(32'hC000_0000 + i));
    expect_frame(wq, 4);
    clear_cnt();
    start_frame(4);
    for (int i = 0; i < 4; i++) begin
      push_word(wq[i]);
      repeat (2) @(negedge clk);
      check("t3_no_early_beat", (i < 3) ? valid_cnt : 0, 0);
    end
    finish_frame("t3", 40);
    check("t3_pops", fire_cnt, 4);

    // 4) downstream stall
    wq.delete();
    for (int i = 0; i < 4; i++) begin wq.push_back(DW'(64'hDEAD_0000_0000_0010 + i)); push_word(wq[i]); end
    expect_frame(wq, 4);
    clear_cnt();
    out_ready = 1'b0;
    start_frame(4);
    n = 0;
    while (valid_cnt == 0 && n < 40) begin @(negedge clk); n++; end
    check("t4_valid_seen", valid_cnt != 0, 1);
    repeat (5) @(negedge clk);
    check("t4_held_valid", out_valid, 1);
    check("t4_stall_cycles", valid_cnt, 6);
    check("t4_sb_waiting", sb.size(), 1);
    out_ready = 1'b1;
    finish_frame("t4", 40);

    // 5) zero-length frame
    clear_cnt();
    start_frame(0);
    repeat (4) @(negedge clk);
    check("t5_done_pulses", done_cnt, 1);
    check("t5_no_beat", valid_cnt, 0);
    check("t5_no_pop", fire_cnt, 0);
    check("t5_busy_short", (busy_cnt >= 1) && (busy_cnt <= 2), 1);

    // 6) reset mid-frame, then a clean frame
    wq.delete();
    for (int i = 0; i < 8; i++) begin wq.push_back(DW'(16'hE000 + i)); push_word(wq[i]); end
    expect_frame(wq, 8);
    clear_cnt();
    start_frame(8);
    n = 0;
    while (fire_cnt < 2 && n < 40) begin @(negedge clk); n++; end
    check("t6_two_pops", fire_cnt >= 2, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_abort");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wq.delete();
    for (int i = 0; i < 4; i++) begin wq.push_back(DW'(8'h51 + i)); push_word(wq[i]); end
    expect_frame(wq, 4);
    clear_cnt();
    start_frame(4);
    finish_frame("t6", 40);
    check("t6_clean_beat", valid_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
